fir_decimator_mc: RTL and testbench

- Multi-channel, time-multiplexed, signed decimating FIR for the audio path; successor to the single-channel pre-filter.
- Sits between the PSG/FM mixers (source rate) and the resampler/output stage; accepts samples via valid/ready, emits one filtered frame per DECIM inputs.
- Single shared multiply-accumulator (MAC), runtime-writable coefficient bank, round-half-up and saturation on output.

---
 rtl/fir_decimator_mc.sv | 169 ++++++++++++++++
 tb/tb_fir_decimator_mc.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_decimator_mc.sv
// fir_decimator_mc: time-multiplexed multi-channel decimating FIR with one
// shared MAC, runtime coefficient bank, round-half-up and output saturation.
module fir_decimator_mc #(
    parameter int IW       = 16,
    parameter int CW       = 16,
    parameter int TAPS     = 32,
    parameter int CHANNELS = 2,
    parameter int DECIM    = 6
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [CHANNELS*IW-1:0]   in_data,
    input  logic                     coef_we,
    input  logic [$clog2(TAPS)-1:0]  coef_addr,
    input  logic [CW-1:0]            coef_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [CHANNELS*IW-1:0]   out_data,
    output logic [CHANNELS-1:0]      out_sat
);

    localparam int TW  = $clog2(TAPS);
    localparam int CHW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int PHW = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam int PW  = IW + CW;
    localparam int AW  = IW + CW + TW;

    localparam logic signed [AW-1:0] RND  = AW'(2 ** (CW - 2));
    localparam logic signed [AW-1:0] YMAX = AW'(2 ** (IW - 1) - 1);
    localparam logic signed [AW-1:0] YMIN = ~YMAX;
    localparam logic signed [CW-1:0] HONE = CW'(2 ** (CW - 1) - 1);

    typedef enum logic [1:0] {
        IDLE,
        MAC,
        ROUND,
        OUT
    } state_t;

    state_t state;

    logic signed [IW-1:0] hist [CHANNELS][TAPS];
    logic signed [CW-1:0] coef [TAPS];

    logic [TW-1:0]  wptr;
    logic [TW-1:0]  rptr;
    logic [TW-1:0]  tap;
    logic [CHW-1:0] chan;
    logic [PHW-1:0] phase;

    logic signed [AW-1:0] acc;

    logic signed [IW-1:0] x_sel;
    logic signed [CW-1:0] h_sel;
    logic        [PW-1:0] prod;
    logic signed [AW-1:0] prod_ext;
    logic signed [AW-1:0] rsum;
    logic signed [AW-1:0] y_full;
    logic                 y_hi;
    logic                 y_lo;
    logic        [IW-1:0] y_sat;

    assign x_sel = hist[chan][rptr];
    assign h_sel = coef[tap];

    // Operands sign-extended to the full product width, so the low PW bits
    // of the unsigned multiply are the exact signed product.
    assign prod = {{CW{x_sel[IW-1]}}, x_sel}
                * {{IW{h_sel[CW-1]}}, h_sel};

    assign prod_ext = {{TW{prod[PW-1]}}, prod};

    assign rsum   = acc + RND;
    assign y_full = rsum >>> (CW - 1);
    assign y_hi   = y_full > YMAX;
    assign y_lo   = y_full < YMIN;
    assign y_sat  = y_hi ? YMAX[IW-1:0]
                  : y_lo ? YMIN[IW-1:0]
                  : y_full[IW-1:0];

    // Handshake FSM, sample history, coefficient bank and the shared MAC.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sat   <= '0;
            wptr      <= '0;
            rptr      <= '0;
            tap       <= '0;
            chan      <= '0;
            phase     <= '0;
            acc       <= '0;
            for (int c = 0; c < CHANNELS; c++) begin
                for (int k = 0; k < TAPS; k++) begin
                    hist[c][k] <= '0;
                end
            end
            for (int k = 0; k < TAPS; k++) begin
                coef[k] <= (k == 0) ? HONE : '0;
            end
        end else begin
            unique case (state)
                IDLE: begin
                    if (coef_we) begin
                        coef[coef_addr] <= coef_data;
                    end
                    if (in_valid && in_ready) begin
                        for (int c = 0; c < CHANNELS; c++) begin
                            hist[c][wptr] <= in_data[c*IW +: IW];
                        end
                        wptr <= (wptr == TW'(TAPS - 1))
                              ? '0 : wptr + TW'(1);
                        if (phase == PHW'(DECIM - 1)) begin
                            phase    <= '0;
                            state    <= MAC;
                            in_ready <= 1'b0;
                            rptr     <= wptr;
                            tap      <= '0;
                            chan     <= '0;
                        end else begin
                            phase <= phase + PHW'(1);
                        end
                    end
                end
                MAC: begin
                    acc <= (tap == '0) ? prod_ext : acc + prod_ext;
                    // TAPS decrements bring rptr back to the newest sample,
                    // ready for the next channel.
                    rptr <= (rptr == '0)
                          ? TW'(TAPS - 1) : rptr - TW'(1);
                    if (tap == TW'(TAPS - 1)) begin
                        state <= ROUND;
                    end else begin
                        tap <= tap + TW'(1);
                    end
                end
                ROUND: begin
                    for (int c = 0; c < CHANNELS; c++) begin
                        if (chan == CHW'(c)) begin
                            out_data[c*IW +: IW] <= y_sat;
                            out_sat[c]           <= y_hi | y_lo;
                        end
                    end
                    tap <= '0;
                    if (chan == CHW'(CHANNELS - 1)) begin
                        state     <= OUT;
                        out_valid <= 1'b1;
                    end else begin
                        chan  <= chan + CHW'(1);
                        state <= MAC;
                    end
                end
                OUT: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fir_decimator_mc.sv
// tb_fir_decimator_mc: directed and randomized frames checked against a
// plain-arithmetic convolution model of the decimating FIR.
module tb_fir_decimator_mc;

    localparam int IW       = 16;
    localparam int CW       = 16;
    localparam int TAPS     = 32;
    localparam int CHANNELS = 2;
    localparam int DECIM    = 6;
    localparam int LAT      = CHANNELS * (TAPS + 1);

    logic                   clk = 1'b0;
    logic                   reset = 1'b1;
    logic                   in_valid = 1'b0;
    logic                   in_ready;
    logic [CHANNELS*IW-1:0] in_data = '0;
    logic                   coef_we = 1'b0;
    logic [4:0]             coef_addr = '0;
    logic [CW-1:0]          coef_data = '0;
    logic                   out_valid;
    logic                   out_ready = 1'b1;
    logic [CHANNELS*IW-1:0] out_data;
    logic [CHANNELS-1:0]    out_sat;

    int     checks   = 0;
    int     failures = 0;
    longint cyc      = 0;
    int     outs     = 0;
    int     bp_mode  = 0;
    logic   prev_ov  = 1'b0;

    typedef struct {
        longint d0;
        longint d1;
        int     sat;
        longint cyc;
    } exp_t;

    exp_t   exp_q[$];
    longint mh[TAPS];
    longint smp[CHANNELS][512];
    int     nsmp;
    int     mphase;

    fir_decimator_mc #(
        .IW(IW), .CW(CW), .TAPS(TAPS),
        .CHANNELS(CHANNELS), .DECIM(DECIM)
    ) dut (
        .clk(clk),
        .reset(reset),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_data(in_data),
        .coef_we(coef_we),
        .coef_addr(coef_addr),
        .coef_data(coef_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data(out_data),
        .out_sat(out_sat)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag,
                         input logic signed [63:0] got,
                         input logic signed [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic void model_reset();
        for (int k = 0; k < TAPS; k++) mh[k] = 0;
        mh[0]  = 32767;
        nsmp   = 0;
        mphase = 0;
        exp_q.delete();
    endfunction

    // y[n] = sum_k x[n-k]*h[k], rounded half up, clamped to 16 bits.
    function automatic void model_push(input longint a, input longint b);
        exp_t   e;
        longint acc;
        longint y;
        longint ys[CHANNELS];
        int     sat;
        smp[0][nsmp] = a;
        smp[1][nsmp] = b;
        nsmp++;
        mphase++;
        if (mphase == DECIM) begin
            mphase = 0;
            sat = 0;
            for (int c = 0; c < CHANNELS; c++) begin
                acc = 0;
                for (int k = 0; k < TAPS; k++) begin
                    if (nsmp - 1 - k >= 0)
                        acc += smp[c][nsmp-1-k] * mh[k];
                end
                y = (acc + 16384) >>> 15;
                if (y > 32767) begin
                    y = 32767;
                    sat |= (1 << c);
                end
                if (y < -32768) begin
                    y = -32768;
                    sat |= (1 << c);
                end
                ys[c] = y;
            end
            e.d0  = ys[0];
            e.d1  = ys[1];
            e.sat = sat;
            e.cyc = cyc + LAT;
            exp_q.push_back(e);
        end
    endfunction

    // Output scoreboard: latency on each rising out_valid, data on handshake.
    always @(negedge clk) begin
        if (reset) begin
            prev_ov <= 1'b0;
        end else begin
            if (out_valid && !prev_ov) begin
                if (exp_q.size() != 0)
                    check("latency", cyc, exp_q[0].cyc);
                else
                    check("spurious_valid", out_valid, 0);
            end
            if (out_valid && out_ready && exp_q.size() != 0) begin
                check("out_ch0", $signed(out_data[15:0]), exp_q[0].d0);
                check("out_ch1", $signed(out_data[31:16]), exp_q[0].d1);
                check("out_sat", out_sat, exp_q[0].sat);
                void'(exp_q.pop_front());
                outs++;
            end
            prev_ov <= out_valid;
        end
    end

    // Downstream ready: always, random, or held low.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (bp_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = 1'($urandom_range(0, 1));
                default: out_ready = 1'b0;
            endcase
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        reset    = 1'b1;
        in_valid = 1'b0;
        coef_we  = 1'b0;
        model_reset();
        @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 1);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("rst_out_data", out_data, 0);
        check("rst_out_sat", out_sat, 0);
        @(posedge clk);
        #1;
    endtask

    task automatic send(input longint a, input longint b);
        int n;
        n = 0;
        in_data  = {16'(b), 16'(a)};
        in_valid = 1'b1;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            n++;
            if (n > 3000) break;
        end
        check("send_accept", n <= 3000, 1);
        @(posedge clk);
        #1;
        if (n <= 3000) model_push(a, b);
        in_valid = 1'b0;
    endtask

    task automatic write_coef(input int a, input longint d, input bit apply);
        coef_we   = 1'b1;
        coef_addr = 5'(a);
        coef_data = 16'(d);
        if (apply) mh[a] = d;
        @(posedge clk);
        #1;
        coef_we = 1'b0;
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || out_valid) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("drain", n < budget, 1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int                   o0;
        int                   n;
        int                   bad;
        logic [31:0]          cap;
        logic signed [15:0]   r;
        longint               d;

        #1;
        do_reset();

        // Identity coefficients: one frame out per six transfers.
        o0 = outs;
        repeat (6) send(1000, -1000);
        drain(500);
        check("t1_count", outs - o0, 1);

        // Ramp coefficients, impulse on ch0.
        do_reset();
        for (int k = 0; k < TAPS; k++) write_coef(k, 512 * k, 1'b1);
        send(16384, 0);
        repeat (17) send(0, 0);
        drain(1000);

        // Full-scale taps and inputs: both channels clamp.
        do_reset();
        for (int k = 0; k < TAPS; k++) write_coef(k, 32767, 1'b1);
        repeat (36) send(32767, -32768);
        drain(1000);
        check("t3_ch0_hold", $signed(out_data[15:0]), 32767);
        check("t3_ch1_hold", $signed(out_data[31:16]), -32768);

        // Backpressure: output held, inputs refused.
        do_reset();
        bp_mode = 2;
        @(posedge clk);
        #1;
        repeat (6) send(1234, -4321);
        n = 0;
        while (!out_valid && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("bp_valid_seen", out_valid, 1);
        cap = out_data;
        bad = 0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk);
            #1;
            in_valid = 1'(i & 1);
            in_data  = 32'h7fff7fff;
            @(negedge clk);
            if (!out_valid || out_data !== cap || in_ready) bad++;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("bp_hold_bad", bad, 0);
        bp_mode = 0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (out_valid && n < 10);
        check("bp_release_valid", out_valid, 0);
        check("bp_release_ready", in_ready, 1);
        check("bp_data_kept", out_data, cap);
        @(posedge clk);
        #1;
        repeat (6) send(1234, -4321);
        drain(500);

        // Coefficient write while busy is dropped; while idle it lands.
        do_reset();
        repeat (6) send(700, -700);
        @(negedge clk);
        check("t5_busy", in_ready, 0);
        @(posedge clk);
        #1;
        write_coef(0, 0, 1'b0);
        drain(500);
        repeat (6) send(-300, 300);
        drain(500);
        @(negedge clk);
        check("t5_idle", in_ready, 1);
        @(posedge clk);
        #1;
        write_coef(0, 0, 1'b1);
        repeat (6) send(900, -900);
        drain(500);

        // Reset in the middle of an accumulation.
        repeat (6) send(3000, -3000);
        repeat (10) @(posedge clk);
        #1;
        do_reset();
        repeat (6) send(500, 500);
        drain(500);
        check("t6_ch0", $signed(out_data[15:0]), 500);

        // Random coefficients, samples, gaps and downstream stalls.
        do_reset();
        for (int k = 0; k < TAPS; k++) begin
            r = 16'($urandom);
            d = longint'(r) >>> $urandom_range(0, 4);
            write_coef(k, d, 1'b1);
        end
        bp_mode = 1;
        for (int i = 0; i < 48; i++) begin
            r = 16'($urandom);
            d = longint'(r);
            r = 16'($urandom);
            send(d, longint'(r));
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
        end
        drain(8000);
        bp_mode = 0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
